// File: rtl/note_pkg.sv
// Shared lane constants, lane lookup helpers and FSM state encoding
// for the note-highway frame sequencer.
package note_pkg;

    localparam logic [2:0] LANE_EMPTY   = 3'd0;
    localparam logic [2:0] LANE_1       = 3'd1;
    localparam logic [2:0] LANE_2       = 3'd2;
    localparam logic [2:0] LANE_3       = 3'd3;
    localparam logic [2:0] LANE_4       = 3'd4;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_ADVANCE,
        ST_DRAW,
        ST_DONE
    } state_e;

    // Codes 5..7 are unused encodings and paint nothing.
    function automatic logic lane_valid(input logic [2:0] code);
        return (code >= LANE_1) && (code <= LANE_4);
    endfunction

    function automatic logic [8:0] lane_x0(input logic [2:0] code);
        case (code)
            LANE_1:  return 9'd120;
            LANE_2:  return 9'd140;
            LANE_3:  return 9'd160;
            LANE_4:  return 9'd180;
            default: return 9'd0;
        endcase
    endfunction

    function automatic logic [2:0] lane_colour(input logic [2:0] code);
        case (code)
            LANE_1:  return 3'b100;
            LANE_2:  return 3'b010;
            LANE_3:  return 3'b001;
            LANE_4:  return 3'b110;
            default: return COLOUR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/span_painter.sv
// Emits SPAN_W horizontally consecutive pixel writes after a start pulse;
// span_done marks the cycle carrying the last pixel.
module span_painter #(
    parameter int unsigned SPAN_W = 20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [8:0] x0,
    input  logic [7:0] y,
    input  logic [2:0] colour,
    output logic [8:0] x_out,
    output logic [7:0] y_out,
    output logic [2:0] c_out,
    output logic       writeEN,
    output logic       span_done
);

    localparam int unsigned CW = (SPAN_W > 1) ? $clog2(SPAN_W) : 1;

    logic [CW-1:0] cnt_q;
    logic [8:0]    x_q;
    logic [7:0]    y_q;
    logic [2:0]    c_q;
    logic          we_q;
    logic          last;

    assign last      = (cnt_q == CW'(SPAN_W - 1));
    assign span_done = we_q && last;

    // A start on the last pixel cycle chains the next span with no gap.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            c_q   <= '0;
            we_q  <= 1'b0;
        end else if (start) begin
            cnt_q <= '0;
            x_q   <= x0;
            y_q   <= y;
            c_q   <= colour;
            we_q  <= 1'b1;
        end else if (we_q) begin
            if (last) begin
                cnt_q <= '0;
                x_q   <= '0;
                y_q   <= '0;
                c_q   <= '0;
                we_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
                x_q   <= x_q + 9'd1;
            end
        end
    end

    assign x_out   = x_q;
    assign y_out   = y_q;
    assign c_out   = c_q;
    assign writeEN = we_q;

endmodule

// File: rtl/note_frame_sequencer.sv
// Per-frame erase / scroll / redraw scheduler owning the VGA pixel-write port.
// All pixel traffic goes through a single shared span_painter.
module note_frame_sequencer
    import note_pkg::*;
#(
    parameter int unsigned NUM_ROWS   = 4,
    parameter int unsigned ROW_PITCH  = 40,
    parameter int unsigned OFFSET_MAX = 39,
    parameter int unsigned SPAN_W     = 20
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  frame_tick,
    input  logic                  enable,
    input  logic [3*NUM_ROWS-1:0] row_code,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun,
    output logic [5:0]            offset,
    output logic [8:0]            x_out,
    output logic [7:0]            y_out,
    output logic [2:0]            c_out,
    output logic                  writeEN
);

    localparam int unsigned RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    state_e                state_q;
    logic [RW-1:0]         row_q;
    logic [5:0]            offset_q, offset_d;
    logic [3*NUM_ROWS-1:0] prev_codes_q, cur_codes_q;
    logic                  busy_q, frame_done_q, overrun_q;

    logic [2:0]    row_cur_code;
    logic          row_fin, last_row, span_done;
    logic          enter, ent_draw;
    logic [RW-1:0] ent_row;
    logic [2:0]    ent_code;
    logic [5:0]    ent_off;
    logic          paint_start;
    logic [8:0]    paint_x0;
    logic [7:0]    paint_y;
    logic [2:0]    paint_colour;

    assign offset_d = (offset_q == 6'(OFFSET_MAX)) ? 6'd0 : offset_q + 6'd1;
    assign last_row = (row_q == RW'(NUM_ROWS - 1));

    always_comb begin
        row_cur_code = '0;
        if (state_q == ST_ERASE) row_cur_code = prev_codes_q[3*int'(row_q) +: 3];
        else                     row_cur_code = cur_codes_q[3*int'(row_q) +: 3];
        row_fin = !lane_valid(row_cur_code) || span_done;
    end

    // Painter is started on the edge that enters a row, so its registered
    // pixels line up with the cycles the FSM spends on that row.
    always_comb begin
        enter    = 1'b0;
        ent_draw = 1'b0;
        ent_row  = '0;
        ent_code = LANE_EMPTY;
        ent_off  = offset_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_tick && enable) begin
                    enter    = 1'b1;
                    ent_code = prev_codes_q[2:0];
                end
            end
            ST_ERASE: begin
                if (row_fin && !last_row) begin
                    enter    = 1'b1;
                    ent_row  = row_q + RW'(1);
                    ent_code = prev_codes_q[3*int'(ent_row) +: 3];
                end
            end
            ST_ADVANCE: begin
                enter    = 1'b1;
                ent_draw = 1'b1;
                ent_code = cur_codes_q[2:0];
                ent_off  = offset_d;
            end
            ST_DRAW: begin
                if (row_fin && !last_row) begin
                    enter    = 1'b1;
                    ent_draw = 1'b1;
                    ent_row  = row_q + RW'(1);
                    ent_code = cur_codes_q[3*int'(ent_row) +: 3];
                end
            end
            default: ;
        endcase
        paint_start  = enter && lane_valid(ent_code);
        paint_x0     = lane_x0(ent_code);
        paint_colour = ent_draw ? lane_colour(ent_code) : COLOUR_BLACK;
        paint_y      = 8'(int'(ent_row) * ROW_PITCH) + {2'b00, ent_off};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            offset_q     <= '0;
            prev_codes_q <= '0;
            cur_codes_q  <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q    <= frame_tick && (state_q != ST_IDLE);
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_tick && enable) begin
                        cur_codes_q <= row_code;
                        row_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ERASE;
                    end
                end
                ST_ERASE: begin
                    if (row_fin) begin
                        if (last_row) state_q <= ST_ADVANCE;
                        else          row_q   <= row_q + RW'(1);
                    end
                end
                ST_ADVANCE: begin
                    offset_q     <= offset_d;
                    prev_codes_q <= cur_codes_q;
                    row_q        <= '0;
                    state_q      <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (row_fin) begin
                        if (last_row) begin
                            state_q      <= ST_DONE;
                            frame_done_q <= 1'b1;
                        end else begin
                            row_q <= row_q + RW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    span_painter #(.SPAN_W(SPAN_W)) u_painter (
        .clk       (clk),
        .resetn    (resetn),
        .start     (paint_start),
        .x0        (paint_x0),
        .y         (paint_y),
        .colour    (paint_colour),
        .x_out     (x_out),
        .y_out     (y_out),
        .c_out     (c_out),
        .writeEN   (writeEN),
        .span_done (span_done)
    );

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    assign offset     = offset_q;

endmodule

// File: tb/tb_note_frame_sequencer.sv
// Directed self-checking bench for note_frame_sequencer (default parameters).
module tb_note_frame_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        frame_tick;
    logic        enable;
    logic [11:0] row_code;
    logic        busy, frame_done, overrun, writeEN;
    logic [5:0]  offset;
    logic [8:0]  x_out;
    logic [7:0]  y_out;
    logic [2:0]  c_out;

    int vectors     = 0;
    int miscompares = 0;

    int wx[$];
    int wy[$];
    int wc[$];
    int nbusy, done_at, novr, zero_bad, first_wr, timed_out;

    always #5 clk = ~clk;

    note_frame_sequencer dut (
        .clk        (clk),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .enable     (enable),
        .row_code   (row_code),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .offset     (offset),
        .x_out      (x_out),
        .y_out      (y_out),
        .c_out      (c_out),
        .writeEN    (writeEN)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issues one tick (optionally held high for the whole frame) and records
    // every cycle until busy drops, bounded by a cycle budget.
    task automatic run_frame(input logic [11:0] codes, input bit hold);
        wx.delete(); wy.delete(); wc.delete();
        nbusy = 0; done_at = 0; novr = 0; zero_bad = 0; first_wr = 0; timed_out = 1;
        row_code   = codes;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        if (!hold) frame_tick = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (busy) nbusy++;
            if (overrun) novr++;
            if (frame_done) done_at = cyc;
            if (writeEN) begin
                wx.push_back(int'(x_out));
                wy.push_back(int'(y_out));
                wc.push_back(int'(c_out));
                if (first_wr == 0) first_wr = cyc;
            end else if ((x_out != 0) || (y_out != 0) || (c_out != 0)) begin
                zero_bad++;
            end
            if (!busy) begin
                timed_out = 0;
                break;
            end
            @(posedge clk); #1;
        end
        frame_tick = 1'b0;
    endtask

    initial begin
        int seg_x[3];
        int seg_y[3];
        int seg_c[3];
        int idle_busy;
        seg_x = '{120, 180, 140};
        seg_y = '{1, 81, 121};
        seg_c = '{4, 6, 2};

        resetn = 1'b0; frame_tick = 1'b0; enable = 1'b1; row_code = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we",      writeEN, 0);
        check("rst_busy",    busy, 0);
        check("rst_done",    frame_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_offset",  offset, 0);
        check("rst_xyc",     {x_out, y_out, c_out}, 0);
        resetn = 1'b1;

        // Tick with enable low is ignored and does not flag overrun.
        enable = 1'b0; frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        check("dis_busy", busy, 0);
        check("dis_overrun", overrun, 0);
        @(posedge clk); #1;
        check("dis_busy2", busy, 0);
        enable = 1'b1;

        // Frame 1: r3=2, r2=4, r1=0, r0=1; nothing to erase yet.
        run_frame({3'd2, 3'd4, 3'd0, 3'd1}, 1'b0);
        check("f1_timeout",  timed_out, 0);
        check("f1_busy",     nbusy, 67);
        check("f1_done_at",  done_at, 67);
        check("f1_first_wr", first_wr, 6);
        check("f1_nwr",      wx.size(), 60);
        check("f1_zero",     zero_bad, 0);
        check("f1_offset",   offset, 1);
        check("f1_overrun",  novr, 0);
        for (int i = 0; i < 60; i++) begin
            check("f1_x", wx[i], seg_x[i/20] + i % 20);
            check("f1_y", wy[i], seg_y[i/20]);
            check("f1_c", wc[i], seg_c[i/20]);
        end

        // Frame 2: all empty; erases frame 1's pixels at offset 1.
        run_frame(12'h000, 1'b0);
        check("f2_busy",   nbusy, 67);
        check("f2_nwr",    wx.size(), 60);
        check("f2_zero",   zero_bad, 0);
        check("f2_offset", offset, 2);
        for (int i = 0; i < 60; i++) begin
            check("f2_x", wx[i], seg_x[i/20] + i % 20);
            check("f2_y", wy[i], seg_y[i/20]);
            check("f2_c", wc[i], 0);
        end

        // Scroll up to OFFSET_MAX with row0 on lane 3.
        for (int f = 0; f < 37; f++) run_frame(12'h003, 1'b0);
        check("pre_wrap_offset", offset, 39);
        run_frame(12'h003, 1'b0);
        check("wrap_busy",   nbusy, 48);
        check("wrap_nwr",    wx.size(), 40);
        check("wrap_e_x0",   wx[0], 160);
        check("wrap_e_x19",  wx[19], 179);
        check("wrap_e_y",    wy[0], 39);
        check("wrap_e_c",    wc[0], 0);
        check("wrap_d_x0",   wx[20], 160);
        check("wrap_d_x19",  wx[39], 179);
        check("wrap_d_y",    wy[39], 0);
        check("wrap_d_c",    wc[20], 1);
        check("wrap_offset", offset, 0);

        // Codes 5..7 are empty rows.
        run_frame({3'd5, 3'd6, 3'd7, 3'd5}, 1'b0);
        check("c567a_busy", nbusy, 29);
        check("c567a_nwr",  wx.size(), 20);
        run_frame({3'd5, 3'd6, 3'd7, 3'd5}, 1'b0);
        check("c567b_busy", nbusy, 10);
        check("c567b_nwr",  wx.size(), 0);
        check("c567_offset", offset, 2);

        // Tick held through the whole frame including DONE.
        run_frame(12'h001, 1'b1);
        check("ovr_busy",  nbusy, 29);
        check("ovr_count", novr, 29);
        check("ovr_nwr",   wx.size(), 20);
        idle_busy = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (busy) idle_busy++;
        end
        check("ovr_no_restart", idle_busy, 0);
        check("ovr_offset", offset, 3);

        // Reset asserted mid-DRAW (row0 lane 2 being drawn at offset 4).
        row_code = 12'h002; frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        repeat (29) begin
            @(posedge clk); #1;
        end
        check("mid_we", writeEN, 1);
        check("mid_x",  x_out, 145);
        check("mid_y",  y_out, 4);
        check("mid_c",  c_out, 2);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("mrst_we",     writeEN, 0);
        check("mrst_offset", offset, 0);
        check("mrst_busy",   busy, 0);
        check("mrst_xyc",    {x_out, y_out, c_out}, 0);
        resetn = 1'b1;
        run_frame(12'h000, 1'b0);
        check("post_rst_nwr",    wx.size(), 0);
        check("post_rst_busy",   nbusy, 10);
        check("post_rst_offset", offset, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
